// File: rtl/bmp_pkg.sv
// bmp_pkg: shared types and constants for the BMP pixel source.
//   bmp_state_e   - frame sequencer states
//   PH_B/G/R      - byte phase within one stored pixel (BMP stores B,G,R)
//   row_pad()     - bytes needed to bring a row of `w` pixels to a 4-byte boundary
package bmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } bmp_state_e;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int ROW_ALIGN       = 4;

  localparam logic [1:0] PH_B = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_R = 2'd2;

  // Only the low two bits of the width matter for alignment to 4 bytes.
  function automatic logic [1:0] row_pad(input logic [1:0] w_lo);
    logic [1:0] m;
    m = w_lo * BYTES_PER_PIXEL[1:0];
    return 2'(ROW_ALIGN - int'(m));
  endfunction

endpackage

// File: rtl/bmp_addr_gen.sv
// bmp_addr_gen: byte address sequencer for bottom-up 24-bit BMP pixel data.
// Owns the byte-phase, column and row counters and the address register.
//   load          - latch base/width/height and restart counters
//   adv           - one read is being issued this cycle; step to the next byte
//   addr          - current read address
//   phase         - byte phase of the current address (PH_B/PH_G/PH_R)
//   last          - current address is the final byte of the frame
// Build option: BMP_ROW_PAD_EN inserts BMP row padding as an address jump.
module bmp_addr_gen
  import bmp_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        phase,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, step;
  logic [1:0]        ph_q;
  logic [DIM_W-1:0]  col_q, row_q, w_q, h_q;
  logic              col_last, row_last, row_end;

  assign col_last = (col_q == w_q - 1'b1);
  assign row_last = (row_q == h_q - 1'b1);
  assign row_end  = (ph_q == PH_R) && col_last;

  assign addr  = addr_q;
  assign phase = ph_q;
  assign last  = row_end && row_last;

  // The pad is folded into the step after the row's final byte, so padding
  // costs no extra read cycles.
  always_comb begin
    step = ADDR_W'(1);
`ifdef BMP_ROW_PAD_EN
    if (row_end) step = ADDR_W'(1) + ADDR_W'(row_pad(w_q[1:0]));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      ph_q   <= PH_B;
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else if (load) begin
      addr_q <= base;
      ph_q   <= PH_B;
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= width;
      h_q    <= height;
    end else if (adv) begin
      addr_q <= addr_q + step;
      if (ph_q == PH_R) begin
        ph_q <= PH_B;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        ph_q <= ph_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/bmp_pixel_src.sv
// bmp_pixel_src: replays a stored 24-bit BMP frame as a camera pixel stream.
//   start_i/base_addr_i/width_i/height_i - frame request (sampled in IDLE only)
//   mem_rd_o/mem_addr_o/mem_data_i       - byte memory, 1-cycle read latency
//   cam_red/green/blue_o, cam_done_o     - reassembled pixel + 1-cycle strobe
//   busy_o                               - high while fetching or draining
//   frame_done_o                         - 1-cycle end-of-frame pulse
// Build option: BMP_ROW_PAD_EN skips BMP row padding (see bmp_addr_gen).
module bmp_pixel_src
  import bmp_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        cam_red_o,
  output logic [7:0]        cam_green_o,
  output logic [7:0]        cam_blue_o,
  output logic              cam_done_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  bmp_state_e state, next;
  logic       load, adv, last, drain_cnt;
  logic [1:0] phase;
  logic       rd_q;
  logic [1:0] ph_q;
  logic [7:0] hold_b, hold_g;

  assign load         = (state == ST_IDLE) && start_i;
  assign adv          = (state == ST_FETCH);
  assign mem_rd_o     = adv;
  assign busy_o       = (state == ST_FETCH) || (state == ST_DRAIN);
  assign frame_done_o = (state == ST_FIN);

  bmp_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .adv    (adv),
    .base   (base_addr_i),
    .width  (width_i),
    .height (height_i),
    .addr   (mem_addr_o),
    .phase  (phase),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:  if (start_i)
                  next = (width_i != '0 && height_i != '0) ? ST_FETCH : ST_FIN;
      ST_FETCH: if (last) next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) next = ST_FIN;
      ST_FIN:   next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  // Two drain cycles: one for the memory latency, one for the output register.
  always_ff @(posedge clk) begin
    if (rst)                    drain_cnt <= 1'b0;
    else if (state == ST_DRAIN) drain_cnt <= ~drain_cnt;
    else                        drain_cnt <= 1'b0;
  end

  // rd_q/ph_q tag the byte arriving this cycle; clearing rd_q on reset drops
  // any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= 1'b0;
      ph_q        <= PH_B;
      hold_b      <= '0;
      hold_g      <= '0;
      cam_red_o   <= '0;
      cam_green_o <= '0;
      cam_blue_o  <= '0;
      cam_done_o  <= 1'b0;
    end else begin
      rd_q       <= adv;
      ph_q       <= phase;
      cam_done_o <= 1'b0;
      if (rd_q) begin
        case (ph_q)
          PH_B: hold_b <= mem_data_i;
          PH_G: hold_g <= mem_data_i;
          PH_R: begin
            cam_blue_o  <= hold_b;
            cam_green_o <= hold_g;
            cam_red_o   <= mem_data_i;
            cam_done_o  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bmp_pixel_src.md
Name: bmp_pixel_src

Overview:
- Streaming pixel source on the camera side of the Sobel pipeline. It drives the cam_red/cam_green/cam_blue/cam_done stream that the Sobel module consumes.
- Reads 24-bit BMP pixel data, stored bottom-up as B,G,R bytes, from a byte-wide synchronous-read memory.
- Reassembles each pixel and emits one one-cycle done strobe per pixel.
- Turns the stored frame into a hardware stimulus and playback source.

Parameters:
- ADDR_W, 20, byte address width into the pixel memory; 2^20 bytes covers a 1000*1024-byte image buffer.
- DIM_W, 16, width of the image width/height inputs and their internal counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  frame start pulse; sampled only in IDLE
- base_addr_i  in  ADDR_W  byte address of the first pixel (BMP pixel-data start offset)
- width_i  in  DIM_W  pixels per row
- height_i  in  DIM_W  rows per frame
- mem_rd_o  out  1  memory read enable
- mem_addr_o  out  ADDR_W  memory byte address
- mem_data_i  in  8  read data, valid exactly 1 cycle after mem_rd_o
- cam_red_o  out  8  pixel red
- cam_green_o  out  8  pixel green
- cam_blue_o  out  8  pixel blue
- cam_done_o  out  1  pixel valid strobe, one cycle per pixel
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, counters are cleared. Reset mid-frame aborts immediately; read data in flight is discarded and no frame_done_o is issued.
- FSM states and transitions:
  - IDLE: start_i=1 latches base, width and height.
    - Both dimensions nonzero: go to FETCH.
    - Either dimension zero: go to FIN.
  - FETCH: issue reads.
  - DRAIN: wait 2 cycles for the last data.
  - FIN: frame_done_o=1 for one cycle, then IDLE.
- Read issue in FETCH:
  - mem_rd_o=1 every cycle, with no gaps.
  - Byte phase cycles 0,1,2 = B,G,R at consecutive addresses.
  - Total reads = width*height*3. After the last read, go to DRAIN.
- Data capture:
  - The byte returned for phase 0/1 is held in a B/G holding register.
  - When the phase-2 byte returns, cam_blue_o, cam_green_o and cam_red_o are loaded together and cam_done_o=1 for that one cycle (registered outputs).
- Latency:
  - If start_i is sampled at edge E0, the first read is in cycle E0+1 and the first cam_done_o is in cycle E0+5.
  - Subsequent cam_done_o pulses come every 3 cycles.
  - The last cam_done_o falls in the final DRAIN cycle; frame_done_o follows in the next cycle.
- busy_o: 1 in FETCH and DRAIN, 0 in IDLE and FIN.
- start_i while busy_o=1 or in FIN is ignored.
- Colour outputs hold their last values while cam_done_o=0.
- Addresses increment modulo 2^ADDR_W; wrap-around is silent.
- Pixel order is memory order: bottom row first, left to right. No row reversal.
- Column and row counters are DIM_W bits. The product width*height*3 is not computed; completion is detected by the last column of the last row at phase 2.

Optional Feature:
- Macro: BMP_ROW_PAD_EN.
- Defined:
  - After the phase-2 read of the last pixel of each row, the next address skips pad = (4 - (width*3 mod 4)) mod 4 bytes, so rows are 4-byte aligned per BMP.
  - The skip is an address jump only; it adds no cycles.
- Undefined:
  - Addresses are strictly contiguous.
  - width_i must be a multiple of 4 (pad=0). Other widths give undefined pixel data but correct pixel and frame counts.

Decomposition:
- Package bmp_pkg:
  - FSM state encoding (IDLE, FETCH, DRAIN, FIN)
  - BYTES_PER_PIXEL=3, ROW_ALIGN=4
  - byte-phase codes PH_B=0, PH_G=1, PH_R=2
- Sub-module bmp_addr_gen:
  - owns the phase, column and row counters, the address register and the pad computation
  - outputs mem_addr, the phase and a last-read flag
- The top level keeps the FSM and the capture/output registers.

Test Plan:
- 4x2 frame, base=0x36, memory byte k = k[7:0]:
  - exactly 8 cam_done_o pulses; first pixel B=0x36, G=0x37, R=0x38
  - first pulse at E0+5, then pulses spaced 3 cycles apart
  - frame_done_o one cycle after the last pulse; busy_o low in that cycle
- width=0, height=5, start:
  - no mem_rd_o
  - frame_done_o at E0+1, with busy_o never high
- Second start_i pulse mid-frame (4x2):
  - ignored; still exactly 8 pulses and one frame_done_o
- rst asserted 10 cycles into a 4x4 frame:
  - next cycle all outputs 0 and state IDLE
  - no frame_done_o
  - a new start produces a full 16-pixel frame from base
- base=2^ADDR_W-3, 2x1 frame:
  - pixel 0 read from the last 3 addresses
  - pixel 1 read from addresses 0,1,2 (wrap)
- With BMP_ROW_PAD_EN, width=3, height=2, base=0:
  - row 1 reads start at address 12 (9 data bytes + 3 pad)
  - 6 pulses; no extra cycles between rows
